latch_write_scheduler: RTL and testbench
========================================

// Module: latch_write_scheduler
//
// PURPOSE
// Shares one transparent D-latch bank (active-high enable `en`, active-low reset `rstn`, data `d`) among
// NUM_REQ requesters using round-robin arbitration.
// Sequences each write as setup -> enable-open -> hold, so `d` is never changed while `en` is high.
// Sits between requester logic and the dlatch bank; it is the only driver of the bank's d/en/rstn.
//
// PARAMETERS
// NUM_REQ      4  number of requesters, >=2
// WIDTH        8  latch bank data width, >=1
// OPEN_CYCLES  2  cycles lat_en is held high per write, >=1
// HOLD_CYCLES  1  cycles lat_d is held stable after lat_en falls, >=1
//
// PORTS
// clk       in   1              single clock, all state on posedge
// rst       in   1              synchronous, active-high reset
// req       in   NUM_REQ        write request per requester; held high until its ack
// wdata     in   NUM_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
// ack       out  NUM_REQ        one-cycle completion pulse to the granted requester
// grant_id  out  GW             index of the current/last granted requester; GW = max(1, $clog2(NUM_REQ))
// busy      out  1              high in every state except IDLE
// lat_d     out  WIDTH          data to the latch bank
// lat_en    out  1              latch enable
// lat_rstn  out  1              latch reset, active-low
//
// BEHAVIOUR
// - Reset values: state=IDLE, ack=0, grant_id=0, busy=0, lat_d=0, lat_en=0, lat_rstn=0, rr pointer=0.
// - lat_rstn is a register: it is 0 while rst is high and in the first cycle after rst falls, then 1.
// - Every output is a register; there is no combinational path from req/wdata to any output.
// - FSM states: IDLE, SETUP, OPEN, HOLD, DONE.
// - IDLE: if any req is set and lat_rstn==1, grant the first set requester scanning upward from the rr pointer
//   with wrap-around. Capture its wdata into lat_d and set grant_id. Go to SETUP.
// - SETUP (1 cycle): lat_en=0 and lat_d is stable. Then go to OPEN.
// - OPEN (OPEN_CYCLES cycles): lat_en=1 and lat_d is unchanged. Then go to HOLD.
// - HOLD (HOLD_CYCLES cycles): lat_en=0 and lat_d is unchanged. Then go to DONE.
// - DONE (1 cycle): ack[grant_id]=1 and rr pointer = (grant_id+1) mod NUM_REQ. Then go to IDLE.
// - ack is one-hot or zero, and is never high outside DONE.
// - Latency from a grant in IDLE to ack = OPEN_CYCLES + HOLD_CYCLES + 2 cycles.
//   Back-to-back writes are spaced OPEN_CYCLES + HOLD_CYCLES + 3 cycles apart.
// - lat_d changes only on the IDLE->SETUP edge. lat_en rises only on SETUP->OPEN and falls only on OPEN->HOLD.
// - req is sampled only in IDLE.
//   - Dropping req mid-transaction does not abort it; it completes and ack is still pulsed.
//   - A req still high in the cycle after DONE counts as a new request.
// - Simultaneous requests: the rr pointer decides the winner. The winner becomes lowest priority next time.
//   No requester waits more than NUM_REQ-1 grants.
// - Reset mid-operation: at the next edge all state returns to reset values. lat_en=0, no ack is issued,
//   and the partial write is lost (the latch is also reset via lat_rstn).
// - Counters are sized to max(OPEN_CYCLES, HOLD_CYCLES) and reload on each state entry.
//
// STRUCTURE
// - Package latch_sched_pkg holds the state encoding (localparam/typedef enum: IDLE=0, SETUP=1, OPEN=2,
//   HOLD=3, DONE=4; 3 bits) and a GW width function.
// - One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, pointer. Outputs: grant one-hot, grant index,
//   valid. Combinational.
// - FSM, counters, data register and ack generation stay in the top module.
//
// TESTING
// 1. Apply rst for 2 cycles, then release with req=0.
//    -> All outputs at their reset values; lat_rstn=0 for one cycle after release, then 1; busy=0.
// 2. Single request: req=4'b0001, wdata[7:0]=8'hA5.
//    -> lat_d=A5 in SETUP; lat_en=1 for exactly 2 cycles; ack[0] pulses 5 cycles after the grant;
//       q of an attached dlatch1 bank = A5.
// 3. Contention: req=4'b1111 held continuously, pointer=0.
//    -> grant order 0,1,2,3,0; each ack is one cycle wide; lat_d never changes while lat_en=1.
// 4. Mid-flight drop: req[2] is deasserted during OPEN.
//    -> The write completes and ack[2] still pulses; no new grant is made for 2.
// 5. rst asserted during OPEN.
//    -> The next cycle has lat_en=0, ack=0, state=IDLE and lat_rstn=0; after release, requests are
//       served again starting from requester 0.

Source files
------------

// File: rtl/latch_write_scheduler_pkg.sv
// Shared definitions for the latch write scheduler: FSM state encoding
// and the grant-index width helper.
package latch_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      OPEN  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int gw_f(input int n);
      int c;
      c = $clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/latch_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above the pointer, wrapping around past the top requester.
module rr_arbiter
   import latch_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [GW-1:0]      grant_idx_o,
   output logic               valid_o
);

   // One spare bit so pointer+offset can exceed NUM_REQ-1 before wrapping.
   localparam int IW = GW + 1;

   logic [IW-1:0] idx_w;

   // Scan offsets from the far end down so the nearest set request wins last.
   always_comb begin
      valid_o     = 1'b0;
      grant_idx_o = '0;
      grant_oh_o  = '0;
      idx_w       = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx_w = {1'b0, ptr_i} + IW'(off);
         if (idx_w >= IW'(NUM_REQ)) begin
            idx_w = idx_w - IW'(NUM_REQ);
         end
         if (req_i[idx_w[GW-1:0]]) begin
            valid_o     = 1'b1;
            grant_idx_o = idx_w[GW-1:0];
         end
      end
      if (valid_o) begin
         grant_oh_o[grant_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/latch_write_scheduler.sv
// Round-robin scheduler sharing one transparent latch bank between several
// requesters. Each write runs setup -> enable-open -> hold so the latch data
// never moves while its enable is high. Every output is a register.
module latch_write_scheduler
   import latch_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int OPEN_CYCLES = 2,
   parameter int HOLD_CYCLES = 1,
   localparam int GW         = gw_f(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]       ack,
   output logic [GW-1:0]            grant_id,
   output logic                     busy,
   output logic [WIDTH-1:0]         lat_d,
   output logic                     lat_en,
   output logic                     lat_rstn
);

   localparam int CMAX = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [GW-1:0]        ptr_q, ptr_d;
   logic [GW-1:0]        grant_id_q;
   logic [NUM_REQ-1:0]   gnt_oh_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [WIDTH-1:0]     lat_d_q;
   logic                 lat_en_q;
   logic                 lat_rstn_q;
   logic                 busy_q;

   logic [NUM_REQ-1:0]   arb_oh;
   logic [GW-1:0]        arb_idx;
   logic                 arb_valid;
   logic [WIDTH-1:0]     sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GW      (GW)
   ) u_arb (
      .req_i       (req),
      .ptr_i       (ptr_q),
      .grant_oh_o  (arb_oh),
      .grant_idx_o (arb_idx),
      .valid_o     (arb_valid)
   );

   // Mux the winning requester's write data out of the packed bus.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_oh[i]) begin
            sel_data = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next state, phase counter (reloads on every state change) and rr pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE:    if (arb_valid && lat_rstn_q) state_d = SETUP;
         SETUP:   state_d = OPEN;
         OPEN:    if (cnt_q == CW'(OPEN_CYCLES - 1)) state_d = HOLD;
         HOLD:    if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
      if (state_q == DONE) begin
         ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
      end
   end

   // State and output registers; outputs are derived from the next state so
   // they line up with the registered state without any comb path to ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         grant_id_q <= '0;
         gnt_oh_q   <= '0;
         ack_q      <= '0;
         lat_d_q    <= '0;
         lat_en_q   <= 1'b0;
         lat_rstn_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         lat_rstn_q <= 1'b1;
         if (state_q == IDLE && state_d == SETUP) begin
            lat_d_q    <= sel_data;
            grant_id_q <= arb_idx;
            gnt_oh_q   <= arb_oh;
         end
         lat_en_q <= (state_d == OPEN);
         busy_q   <= (state_d != IDLE);
         ack_q    <= (state_d == DONE) ? gnt_oh_q : '0;
      end
   end

   assign ack      = ack_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign lat_d    = lat_d_q;
   assign lat_en   = lat_en_q;
   assign lat_rstn = lat_rstn_q;

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Scoreboard bench for latch_write_scheduler: stimulus pushes expected
// completions, a negedge monitor pops and checks them on every ack.
module tb_latch_write_scheduler;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int GW      = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]       ack;
   logic [GW-1:0]            grant_id;
   logic                     busy;
   logic [WIDTH-1:0]         lat_d;
   logic                     lat_en;
   logic                     lat_rstn;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   latch_write_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .WIDTH       (WIDTH),
      .OPEN_CYCLES (2),
      .HOLD_CYCLES (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wdata    (wdata),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .lat_d    (lat_d),
      .lat_en   (lat_en),
      .lat_rstn (lat_rstn)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", nm, act, cyc);
      end
   endtask

   // Monitor: attached latch model, enable-width and data-stability checks,
   // and scoreboard comparison on every ack pulse.
   logic [WIDTH-1:0] latch_q;
   logic [WIDTH-1:0] d_prev;
   logic             en_prev;
   logic             busy_prev;
   int               en_run;
   int               setup_cyc;
   exp_t             e;

   initial begin
      latch_q = '0; d_prev = '0; en_prev = 1'b0; busy_prev = 1'b0;
      en_run = 0; setup_cyc = 0;
   end

   always @(negedge clk) begin
      if (rst) begin
         latch_q = '0; en_prev = 1'b0; busy_prev = 1'b0; en_run = 0;
      end else begin
         if (!lat_rstn)   latch_q = '0;
         else if (lat_en) latch_q = lat_d;
         if (busy && !busy_prev) setup_cyc = cyc;
         if (lat_en && en_prev) chk("d_stable_open", 32'(lat_d), 32'(d_prev));
         if (lat_en) begin
            en_run++;
         end else if (en_prev) begin
            chk("en_width", 32'(en_run), 32'd2);
            en_run = 0;
         end
         if (ack != '0) begin
            if (sb.size() == 0) begin
               chk("ack_expected", 32'(ack), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_onehot", 32'(ack), 32'(1) << e.id);
               chk("grant_id", 32'(grant_id), 32'(e.id));
               chk("lat_d_at_ack", 32'(lat_d), 32'(e.data));
               chk("latch_q", 32'(latch_q), 32'(e.data));
               chk("latency", 32'(cyc - setup_cyc), 32'd4);
            end
         end
         en_prev   = lat_en;
         d_prev    = lat_d;
         busy_prev = busy;
      end
   end

   // Wait for n ack pulses; optionally drop each acked requester's req.
   task automatic wait_acks(input int n, input bit clr, input int budget);
      int got;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         if (ack != '0) begin
            got++;
            if (clr) req = req & ~ack;
         end
      end
      if (got < n) chk("ack_timeout", 32'(got), 32'(n));
   endtask

   task automatic wait_en(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (lat_en) seen = 1'b1;
      end
      if (!seen) chk("en_timeout", 32'(seen), 32'd1);
   endtask

   task automatic push(input int id, input logic [WIDTH-1:0] data);
      exp_t x;
      x.id = id; x.data = data;
      sb.push_back(x);
   endtask

   initial begin
      rst = 1'b1; req = '0; wdata = '0;

      // Reset for two cycles, release just after a rising edge.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lat_d", 32'(lat_d), 32'd0);
      chk("rst_lat_en", 32'(lat_en), 32'd0);
      chk("rst_lat_rstn", 32'(lat_rstn), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstn_first_cycle", 32'(lat_rstn), 32'd0);
      @(negedge clk);
      chk("rstn_released", 32'(lat_rstn), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // Contention with all requests held, pointer starting at 0.
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
      req = 4'b1111;
      wait_acks(5, 1'b0, 60);
      req = '0;
      repeat (3) @(negedge clk);

      // Single request from requester 0.
      wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
      push(0, 8'hA5);
      req = 4'b0001;
      wait_acks(1, 1'b1, 20);
      repeat (2) @(negedge clk);

      // Requester 2 drops its request while the enable is open.
      wdata = {8'h00, 8'hC3, 8'h00, 8'h00};
      push(2, 8'hC3);
      req = 4'b0100;
      wait_en(10);
      req = '0;
      wait_acks(1, 1'b0, 20);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_regrant_busy", 32'(busy), 32'd0);
      end

      // Reset during OPEN: the write is lost, no ack.
      wdata = {8'h5A, 8'h00, 8'h00, 8'h00};
      req = 4'b1000;
      wait_en(10);
      rst = 1'b1; req = '0;
      @(negedge clk);
      chk("midrst_lat_en", 32'(lat_en), 32'd0);
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_lat_rstn", 32'(lat_rstn), 32'd0);
      chk("midrst_grant_id", 32'(grant_id), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // After reset the pointer is back at 0: requester 0 first, then 3.
      wdata = {8'h77, 8'h00, 8'h00, 8'h66};
      push(0, 8'h66); push(3, 8'h77);
      req = 4'b1001;
      wait_acks(2, 1'b1, 40);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
